// File: rtl/font_rom_arbiter_pkg.sv
// Shared constants and types for the glyph ROM arbiter: bus widths, requester ids,
// default timing parameters and the response tag carried alongside each ROM read.
package font_rom_arbiter_pkg;

    localparam int ADDR_W           = 10;
    localparam int DATA_W           = 8;
    localparam int STARVE_W         = 8;
    localparam int DEF_ROM_LAT      = 2;
    localparam int DEF_STARVE_LIMIT = 8;

    typedef enum logic {
        REQ_ID_0 = 1'b0,
        REQ_ID_1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rsp_tag_t;

endpackage

// File: rtl/font_rom_arbiter_if.sv
// Requester, ROM and response signals of the glyph ROM arbiter, bundled for the
// arbiter (slave) and the surrounding system or bench (master).
interface font_rom_arbiter_if;
    import font_rom_arbiter_pkg::*;

    // Handshake: reqN is held with a stable addrN until gntN is seen high; the
    // request is accepted in that same cycle (there is no separate ready). Each
    // accepted request returns exactly one rvalidN pulse with rdata, in grant order.
    logic              prio_mode;
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;

    modport slave (
        input  prio_mode, req0, req1, addr0, addr1, rom_data,
        output gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata
    );

    modport master (
        output prio_mode, req0, req1, addr0, addr1, rom_data,
        input  gnt0, gnt1, rom_en, rom_addr, rvalid0, rvalid1, rdata
    );

endinterface

// File: rtl/font_rom_arbiter_tag_pipe.sv
// Fixed-depth shift pipeline that delays a response tag so it lines up with the
// ROM data belonging to the same grant.
module font_rom_tag_pipe
    import font_rom_arbiter_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  rsp_tag_t tag_i,
    output rsp_tag_t tag_o
);

    rsp_tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-requester arbiter for a shared glyph ROM: round-robin or fixed priority with a
// starvation guard, one read per cycle, responses returned ROM_LAT+2 cycles after grant.
module font_rom_arbiter
    import font_rom_arbiter_pkg::*;
#(
    parameter int ROM_LAT      = DEF_ROM_LAT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                clk_50MHz,
    input  logic                reset,
    font_rom_arbiter_if.slave   bus,
    output logic [STARVE_W-1:0] dbg_starve_cnt_o,
    output req_id_t             dbg_last_gnt_o
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic                gnt0;
    logic                gnt1;
    logic                win1;
    logic [STARVE_W-1:0] starve_q, starve_d;
    req_id_t             last_q, last_d;
    logic                rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    rsp_tag_t            tag_in;
    rsp_tag_t            tag_out;

    always_comb begin
        win1 = 1'b0;
        if (bus.prio_mode) begin
            win1 = (starve_q == LIMIT);
        end else begin
            win1 = (last_q == REQ_ID_0);
        end
        // Grants are gated by the raw reset so nothing is accepted while it is high.
        gnt1 = ~reset & bus.req1 & (~bus.req0 | win1);
        gnt0 = ~reset & bus.req0 & ~(bus.req1 & win1);
    end

    always_comb begin
        starve_d   = starve_q;
        last_d     = last_q;
        rom_en_d   = gnt0 | gnt1;
        rom_addr_d = rom_addr_q;
        tag_in     = '0;
        if (!bus.req1 || gnt1) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
        if (gnt1) begin
            last_d       = REQ_ID_1;
            rom_addr_d   = bus.addr1;
            tag_in.valid = 1'b1;
            tag_in.id    = REQ_ID_1;
        end else if (gnt0) begin
            last_d       = REQ_ID_0;
            rom_addr_d   = bus.addr0;
            tag_in.valid = 1'b1;
            tag_in.id    = REQ_ID_0;
        end
    end

    font_rom_tag_pipe #(
        .DEPTH (ROM_LAT + 1)
    ) u_tag_pipe (
        .clk_i (clk_50MHz),
        .rst_i (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_comb begin
        rvalid0_d = tag_out.valid & (tag_out.id == REQ_ID_0);
        rvalid1_d = tag_out.valid & (tag_out.id == REQ_ID_1);
        rdata_d   = tag_out.valid ? bus.rom_data : rdata_q;
    end

    // last_q resets to requester 1 so that requester 0 wins the first contended cycle.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            starve_q   <= '0;
            last_q     <= REQ_ID_1;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            starve_q   <= starve_d;
            last_q     <= last_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.rom_en       = rom_en_q;
    assign bus.rom_addr     = rom_addr_q;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
    assign bus.rdata        = rdata_q;
    assign dbg_starve_cnt_o = starve_q;
    assign dbg_last_gnt_o   = last_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: three instances (ROM_LAT 2, 1, 4) share one stimulus
// stream; each has its own ROM model and response scoreboard.
module tb_font_rom_arbiter;
    import font_rom_arbiter_pkg::*;

    localparam int EW = 41;

    typedef struct {
        logic       p;
        logic       r0;
        logic       r1;
        logic [9:0] a0;
        logic [9:0] a1;
        logic       g0;
        logic       g1;
        logic       en;
        logic [9:0] raddr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       prio;
    logic       req0;
    logic       req1;
    logic [9:0] addr0;
    logic [9:0] addr1;
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;

    logic       g0_a [3];
    logic       g1_a [3];
    logic       ren_a [3];
    logic [9:0] raddr_a [3];
    logic [7:0] rdat_a [3];
    logic       rv0_a [3];
    logic       rv1_a [3];
    logic [7:0] rdata_a [3];
    logic [7:0] dbg_starve_a [3];
    logic       dbg_last_a [3];

    vec_t vecs [11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    font_rom_arbiter_if if_l2 ();
    font_rom_arbiter_if if_l1 ();
    font_rom_arbiter_if if_l4 ();

    font_rom_arbiter #(.ROM_LAT(2), .STARVE_LIMIT(8)) dut_l2 (
        .clk_50MHz(clk), .reset(rst), .bus(if_l2.slave),
        .dbg_starve_cnt_o(dbg_starve_a[0]), .dbg_last_gnt_o(dbg_last_a[0]));
    font_rom_arbiter #(.ROM_LAT(1), .STARVE_LIMIT(8)) dut_l1 (
        .clk_50MHz(clk), .reset(rst), .bus(if_l1.slave),
        .dbg_starve_cnt_o(dbg_starve_a[1]), .dbg_last_gnt_o(dbg_last_a[1]));
    font_rom_arbiter #(.ROM_LAT(4), .STARVE_LIMIT(8)) dut_l4 (
        .clk_50MHz(clk), .reset(rst), .bus(if_l4.slave),
        .dbg_starve_cnt_o(dbg_starve_a[2]), .dbg_last_gnt_o(dbg_last_a[2]));

    assign if_l2.prio_mode = prio;
    assign if_l2.req0      = req0;
    assign if_l2.req1      = req1;
    assign if_l2.addr0     = addr0;
    assign if_l2.addr1     = addr1;
    assign if_l2.rom_data  = rdat_a[0];
    assign g0_a[0]    = if_l2.gnt0;
    assign g1_a[0]    = if_l2.gnt1;
    assign ren_a[0]   = if_l2.rom_en;
    assign raddr_a[0] = if_l2.rom_addr;
    assign rv0_a[0]   = if_l2.rvalid0;
    assign rv1_a[0]   = if_l2.rvalid1;
    assign rdata_a[0] = if_l2.rdata;

    assign if_l1.prio_mode = prio;
    assign if_l1.req0      = req0;
    assign if_l1.req1      = req1;
    assign if_l1.addr0     = addr0;
    assign if_l1.addr1     = addr1;
    assign if_l1.rom_data  = rdat_a[1];
    assign g0_a[1]    = if_l1.gnt0;
    assign g1_a[1]    = if_l1.gnt1;
    assign ren_a[1]   = if_l1.rom_en;
    assign raddr_a[1] = if_l1.rom_addr;
    assign rv0_a[1]   = if_l1.rvalid0;
    assign rv1_a[1]   = if_l1.rvalid1;
    assign rdata_a[1] = if_l1.rdata;

    assign if_l4.prio_mode = prio;
    assign if_l4.req0      = req0;
    assign if_l4.req1      = req1;
    assign if_l4.addr0     = addr0;
    assign if_l4.addr1     = addr1;
    assign if_l4.rom_data  = rdat_a[2];
    assign g0_a[2]    = if_l4.gnt0;
    assign g1_a[2]    = if_l4.gnt1;
    assign ren_a[2]   = if_l4.rom_en;
    assign raddr_a[2] = if_l4.rom_addr;
    assign rv0_a[2]   = if_l4.rvalid0;
    assign rv1_a[2]   = if_l4.rvalid1;
    assign rdata_a[2] = if_l4.rdata;

    function automatic logic [7:0] romf(input logic [9:0] a);
        return a[7:0] ^ 8'h5A ^ {a[9:8], 6'b0};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h want %0h", name, idx, cyc, act, exp);
        end
    endtask

    // ROM model and response scoreboard per instance.
    for (genvar k = 0; k < 3; k++) begin : gen_chk
        localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
        logic [10:0]   pipe [LAT];
        logic [EW-1:0] exp_q [$];
        logic [EW-1:0] head;

        initial for (int i = 0; i < LAT; i++) pipe[i] = '0;

        always @(posedge clk) begin
            pipe[0] <= {ren_a[k], raddr_a[k]};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        assign rdat_a[k] = pipe[LAT-1][10] ? romf(pipe[LAT-1][9:0]) : 8'hEE;

        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                check("rst_outs", k, {9'b0, g0_a[k], g1_a[k], ren_a[k], rv0_a[k], rv1_a[k],
                                      raddr_a[k], rdata_a[k]}, 32'd0);
            end else begin
                check("gnt_mutex", k, {31'b0, g0_a[k] & g1_a[k]}, 32'd0);
                check("gnt_no_req", k, {31'b0, (g0_a[k] & ~req0) | (g1_a[k] & ~req1)}, 32'd0);
                check("rv_mutex", k, {31'b0, rv0_a[k] & rv1_a[k]}, 32'd0);
                if (exp_q.size() != 0 && exp_q[0][EW-1 -: 32] == cyc) begin
                    head = exp_q.pop_front();
                    check("rsp", k, {22'b0, rv0_a[k], rv1_a[k], rdata_a[k]},
                          {22'b0, ~head[8], head[8], head[7:0]});
                end else begin
                    check("rsp_idle", k, {30'b0, rv0_a[k], rv1_a[k]}, 32'd0);
                end
                if (g0_a[k] | g1_a[k]) begin
                    exp_q.push_back({32'(cyc + LAT + 2), g1_a[k], romf(g1_a[k] ? addr1 : addr0)});
                end
            end
        end
    end

    task automatic drive(input logic p, input logic r0, input logic r1,
                         input logic [9:0] a0, input logic [9:0] a1);
        prio  = p;
        req0  = r0;
        req1  = r1;
        addr0 = a0;
        addr1 = a1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        //          p     r0    r1    a0       a1       g0    g1    en    raddr
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 10'h140, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 10'h141, 10'h200, 1'b0, 1'b1, 1'b1, 10'h140};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 10'h141, 10'h201, 1'b1, 1'b0, 1'b1, 10'h200};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'h141, 10'h201, 1'b0, 1'b0, 1'b1, 10'h141};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 10'h141, 10'h202, 1'b0, 1'b1, 1'b0, 10'h141};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 10'h142, 10'h203, 1'b1, 1'b0, 1'b1, 10'h202};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 10'h143, 10'h203, 1'b1, 1'b0, 1'b1, 10'h142};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 10'h143, 10'h204, 1'b0, 1'b1, 1'b1, 10'h143};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 10'h144, 10'h205, 1'b1, 1'b0, 1'b1, 10'h204};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 10'h144, 10'h205, 1'b0, 1'b0, 1'b1, 10'h144};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 10'h144, 10'h205, 1'b0, 1'b0, 1'b0, 10'h144};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].p, vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].a1);
            @(negedge clk);
            check("vec_gnt", i, {30'b0, g0_a[0], g1_a[0]}, {30'b0, vecs[i].g0, vecs[i].g1});
            check("vec_rom", i, {21'b0, ren_a[0], raddr_a[0]}, {21'b0, vecs[i].en, vecs[i].raddr});
            next_cycle();
        end

        // Single requester back-to-back at 0x140
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 10'h140, 10'h000);
            @(negedge clk);
            check("single_gnt", i, {31'b0, g0_a[0]}, 32'd1);
            if (i >= 1) check("single_rom", i, {21'b0, ren_a[0], raddr_a[0]}, {21'b0, 1'b1, 10'h140});
            if (i == 4) check("single_rsp", i, {23'b0, rv0_a[0], rdata_a[0]}, {23'b0, 1'b1, 8'h5A});
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        repeat (6) next_cycle();

        // Round-robin contention for 6 cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 6) drive(1'b0, 1'b1, 1'b1, 10'(10'h010 + i), 10'(10'h300 + i));
            else       drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
            @(negedge clk);
            if (i < 6) check("rr_gnt", i, {30'b0, g0_a[0], g1_a[0]}, (i % 2 == 1) ? 32'd1 : 32'd2);
            if (i >= 4) check("rr_rsp", i, {30'b0, rv0_a[0], rv1_a[0]}, ((i - 4) % 2 == 1) ? 32'd1 : 32'd2);
            next_cycle();
        end

        // Fixed priority with starvation guard
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1, 1'b1, 10'h0A0, 10'h2B0);
            @(negedge clk);
            check("starve_gnt", i, {30'b0, g0_a[0], g1_a[0]}, (i == 8) ? 32'd1 : 32'd2);
            if (i == 8) check("starve_cnt_sat", i, {24'b0, dbg_starve_a[0]}, 32'd8);
            if (i == 9) check("starve_cnt_clr", i, {24'b0, dbg_starve_a[0]}, 32'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        repeat (6) next_cycle();

        // Reset pulsed with two reads in flight
        do_reset();
        repeat (3) next_cycle();
        drive(1'b0, 1'b1, 1'b0, 10'h0AA, 10'h000);
        next_cycle();
        drive(1'b0, 1'b0, 1'b1, 10'h000, 10'h155);
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 10'h0CC, 10'h000);
        @(negedge clk);
        check("midrst_outs", 0, {1'b0, g0_a[0], g1_a[0], ren_a[0], rv0_a[0], rv1_a[0],
                                 raddr_a[0], rdata_a[0], dbg_starve_a[0]}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("postrst_gnt", 0, {30'b0, g0_a[0], g1_a[0]}, 32'd2);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_no_rv", i, {30'b0, rv0_a[0], rv1_a[0]}, 32'd0);
            next_cycle();
        end
        repeat (4) next_cycle();

        // Random traffic across all three latencies, including prio_mode flips
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) prio = ~prio;
            drive(prio, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        repeat (8) next_cycle();
        check("drain", 0, 32'(gen_chk[0].exp_q.size()), 32'd0);
        check("drain", 1, 32'(gen_chk[1].exp_q.size()), 32'd0);
        check("drain", 2, 32'(gen_chk[2].exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
